// File: rtl/imem_pkg.sv
// Shared types and defaults for the SUBLEQ instruction-memory loader.
package imem_pkg;

   localparam int IMEM_ADDR_W    = 8;
   localparam int IMEM_DATA_W    = 24;
   localparam int IMEM_BYTES     = IMEM_DATA_W / 8;
   localparam int IMEM_BASE_ADDR = 0;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      WRITE,
      CSUM,
      DONE
   } imem_state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs stream bytes MSB-first into one instruction word and flags the byte
// that completes it. word_next already includes the byte being shifted in,
// so the loader can register it into the write data on the same edge.
module imem_word_assembler #(
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              shift_en,
   input  logic [7:0]        byte_in,
   output logic [DATA_W-1:0] word_next,
   output logic              word_last
);

   localparam int BYTES = DATA_W / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [DATA_W-1:0] word_q;
   logic [IDX_W-1:0]  idx_q;

   assign word_next = (word_q << 8) | DATA_W'(byte_in);
   assign word_last = shift_en && (idx_q == IDX_W'(BYTES - 1));

   // shift register and byte index; index wraps when a word completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (clear) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (shift_en) begin
         word_q <= word_next;
         idx_q  <= word_last ? '0 : idx_q + IDX_W'(1);
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream writer for the SUBLEQ IMEM.
// Frame: length byte L, then (L+1) words of DATA_W/8 bytes, MSB byte first.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
// (two's complement of the 8-bit sum of L and all data bytes) and csum_err.
//
// state | meaning
// IDLE  | waiting for start, no bytes accepted
// LEN   | accepting the length byte
// DATA  | accepting data bytes of the current word
// WRITE | one-cycle IMEM write of the assembled word
// CSUM  | accepting the trailing checksum byte (checksum build only)
// DONE  | one-cycle completion pulse, busy drops afterwards
module imem_loader
   import imem_pkg::*;
#(
   parameter int          ADDR_W    = IMEM_ADDR_W,
   parameter int          DATA_W    = IMEM_DATA_W,
   parameter int unsigned BASE_ADDR = IMEM_BASE_ADDR
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
`ifdef IMEM_LOADER_CHECKSUM_EN
   output logic              csum_err,
`endif
   output logic [ADDR_W:0]   words_written
);

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   imem_state_t       state;
   logic [ADDR_W:0]   remaining;
   logic              xfer;
   logic [DATA_W-1:0] word_next;
   logic              word_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        sum;
`endif

   // ready decodes straight from state so the source sees it in the same cycle
   always_comb begin
      byte_ready = 1'b0;
      case (state)
         LEN, DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM:      byte_ready = 1'b1;
`endif
         default:   byte_ready = 1'b0;
      endcase
   end

   assign xfer = byte_valid && byte_ready;

   imem_word_assembler #(
      .DATA_W (DATA_W)
   ) u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (state == IDLE),
      .shift_en  (xfer && (state == DATA)),
      .byte_in   (byte_data),
      .word_next (word_next),
      .word_last (word_last)
   );

   // frame sequencing with registered IMEM write port and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wr_en         <= 1'b0;
         wr_addr       <= BASE;
         wr_data       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         words_written <= '0;
         remaining     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum           <= '0;
         csum_err      <= 1'b0;
`endif
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state         <= LEN;
                  busy          <= 1'b1;
                  words_written <= '0;
                  wr_addr       <= BASE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_err      <= 1'b0;
`endif
               end
            end
            LEN: begin
               if (xfer) begin
                  remaining <= (ADDR_W+1)'(byte_data) + (ADDR_W+1)'(1);
                  state     <= DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum       <= byte_data;
`endif
               end
            end
            DATA: begin
               if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum <= sum + byte_data;
`endif
                  if (word_last) begin
                     state   <= WRITE;
                     wr_en   <= 1'b1;
                     wr_data <= word_next;
                  end
               end
            end
            WRITE: begin
               wr_addr       <= wr_addr + ADDR_W'(1);
               words_written <= words_written + (ADDR_W+1)'(1);
               remaining     <= remaining - (ADDR_W+1)'(1);
               if (remaining == (ADDR_W+1)'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state <= CSUM;
`else
                  state <= DONE;
                  done  <= 1'b1;
`endif
               end else begin
                  state <= DATA;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
               if (xfer) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  csum_err <= (sum + byte_data) != 8'd0;
               end
            end
`endif
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: two instances (base 0 and base 250)
// share one byte stream; expected writes come from the frame contents.
module tb_imem_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;

   logic        byte_ready0, wr_en0, busy0, done0;
   logic [7:0]  wr_addr0;
   logic [23:0] wr_data0;
   logic [8:0]  words_written0;
   logic        byte_ready1, wr_en1, busy1, done1;
   logic [7:0]  wr_addr1;
   logic [23:0] wr_data1;
   logic [8:0]  words_written1;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic        csum_err0, csum_err1;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   imem_loader dut0 (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready0),
      .wr_en         (wr_en0),
      .wr_addr       (wr_addr0),
      .wr_data       (wr_data0),
      .busy          (busy0),
      .done          (done0),
`ifdef IMEM_LOADER_CHECKSUM_EN
      .csum_err      (csum_err0),
`endif
      .words_written (words_written0)
   );

   imem_loader #(.BASE_ADDR(250)) dut1 (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready1),
      .wr_en         (wr_en1),
      .wr_addr       (wr_addr1),
      .wr_data       (wr_data1),
      .busy          (busy1),
      .done          (done1),
`ifdef IMEM_LOADER_CHECKSUM_EN
      .csum_err      (csum_err1),
`endif
      .words_written (words_written1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one complete frame and checks it against the frame contents.
   task automatic run_frame(input string name, input int nwords, input bit rnd,
                            input logic [7:0] first, input logic [7:0] step,
                            input bit gaps, input bit restart, input bit bad_csum);
      logic [7:0]  q[$];
      logic [23:0] exp_w[$];
      logic [7:0]  a0[$], a1[$];
      logic [23:0] d0[$], d1[$];
      logic [7:0]  b, s;
      logic [8:0]  ww0, ww1;
      logic        ce0, ce1;
      int idx, cyc, nmin;
      bit pend, acc, v, seen_done;
      ww0 = '0; ww1 = '0; ce0 = 1'b0; ce1 = 1'b0;
      q.push_back(8'(nwords - 1));
      b = first;
      for (int i = 0; i < nwords * 3; i++) begin
         q.push_back(rnd ? 8'($urandom) : b);
         b = b + step;
      end
      for (int i = 0; i < nwords; i++)
         exp_w.push_back({q[1+3*i], q[2+3*i], q[3+3*i]});
`ifdef IMEM_LOADER_CHECKSUM_EN
      s = '0;
      foreach (q[i]) s = s + q[i];
      q.push_back(bad_csum ? ((8'd0 - s) ^ 8'h5A) : (8'd0 - s));
`else
      s = 8'(bad_csum);
`endif
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      idx = 0; cyc = 0; pend = 1'b0; seen_done = 1'b0;
      while (!seen_done && cyc < 5000) begin
         n_checks++;
         if (wr_en0 !== pend) begin
            n_fail++;
            $display("FAIL %s wr_en timing cyc %0d: got %b want %b", name, cyc, wr_en0, pend);
         end
         n_checks++;
         if (busy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy during frame cyc %0d: got %b want 1", name, cyc, busy0);
         end
         if (wr_en0) begin
            a0.push_back(wr_addr0); d0.push_back(wr_data0);
            n_checks++;
            if (byte_ready0 !== 1'b0) begin
               n_fail++;
               $display("FAIL %s byte_ready in write cycle: got %b want 0", name, byte_ready0);
            end
         end
         if (wr_en1) begin a1.push_back(wr_addr1); d1.push_back(wr_data1); end
         if (done0) begin
            seen_done = 1'b1;
            ww0 = words_written0; ww1 = words_written1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ce0 = csum_err0; ce1 = csum_err1;
`endif
         end
         start = restart && (cyc == 4);
         v = (idx < q.size()) && (!gaps || $urandom_range(0, 2) != 0);
         byte_valid = v;
         byte_data  = v ? q[idx] : 8'($urandom);
         acc  = v && byte_ready0;
         pend = acc && (idx >= 3) && (idx <= nwords * 3) && (idx % 3 == 0);
         if (acc) idx++;
         @(negedge clk);
         cyc++;
      end
      byte_valid = 1'b0;
      start = 1'b0;
      n_checks++;
      if (!seen_done) begin
         n_fail++;
         $display("FAIL %s done timeout: got no done within %0d cycles want done", name, cyc);
      end
      n_checks++;
      if (idx != q.size()) begin
         n_fail++;
         $display("FAIL %s bytes consumed: got %0d want %0d", name, idx, q.size());
      end
      n_checks++;
      if (a0.size() != nwords || a1.size() != nwords) begin
         n_fail++;
         $display("FAIL %s write count: got %0d/%0d want %0d", name, a0.size(), a1.size(), nwords);
      end
      nmin = (a0.size() < a1.size()) ? a0.size() : a1.size();
      if (nmin > nwords) nmin = nwords;
      for (int i = 0; i < nmin; i++) begin
         n_checks++;
         if (a0[i] !== 8'(i) || d0[i] !== exp_w[i]) begin
            n_fail++;
            $display("FAIL %s base0 word %0d: got %h:%h want %h:%h", name, i, a0[i], d0[i], 8'(i), exp_w[i]);
         end
         n_checks++;
         if (a1[i] !== 8'((250 + i) % 256) || d1[i] !== exp_w[i]) begin
            n_fail++;
            $display("FAIL %s base250 word %0d: got %h:%h want %h:%h", name, i, a1[i], d1[i], 8'((250 + i) % 256), exp_w[i]);
         end
      end
      n_checks++;
      if (ww0 !== 9'(nwords) || ww1 !== 9'(nwords)) begin
         n_fail++;
         $display("FAIL %s words_written: got %0d/%0d want %0d", name, ww0, ww1, nwords);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      n_checks++;
      if (ce0 !== bad_csum || ce1 !== bad_csum) begin
         n_fail++;
         $display("FAIL %s csum_err: got %b/%b want %b", name, ce0, ce1, bad_csum);
      end
`endif
      n_checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || wr_en0 !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after done busy/done/wr_en: got %b%b%b want 000 (csum tag %h)", name, busy0, done0, wr_en0, s);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = '0;
      #12;
      n_checks++;
      if ({byte_ready0, wr_en0, busy0, done0, wr_addr0, wr_data0, words_written0} !== {4'b0, 8'd0, 24'd0, 9'd0}
          || wr_addr1 !== 8'd250) begin
         n_fail++;
         $display("FAIL reset values: got rdy%b we%b busy%b done%b a%h/%h d%h ww%0d want 0000 a00/fa d0 ww0",
                  byte_ready0, wr_en0, busy0, done0, wr_addr0, wr_addr1, wr_data0, words_written0);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle_bytes;
      for (int i = 0; i < 6; i++) begin
         byte_valid = 1'b1; byte_data = 8'($urandom);
         @(negedge clk);
         n_checks++;
         if (byte_ready0 !== 1'b0 || busy0 !== 1'b0 || wr_en0 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle bytes: got rdy%b busy%b we%b want 000", byte_ready0, busy0, wr_en0);
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic test_reset_mid;
      int acc_n, cyc;
      logic [7:0] bytes[5];
      bytes = '{8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      acc_n = 0; cyc = 0;
      while (acc_n < 5 && cyc < 50) begin
         byte_valid = 1'b1; byte_data = bytes[acc_n];
         if (byte_ready0) acc_n++;
         @(negedge clk);
         cyc++;
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({byte_ready0, wr_en0, busy0, done0, wr_addr0, wr_data0, words_written0} !== {4'b0, 8'd0, 24'd0, 9'd0}
          || wr_addr1 !== 8'd250 || acc_n != 5) begin
         n_fail++;
         $display("FAIL reset mid-frame: got rdy%b we%b busy%b done%b a%h d%h ww%0d acc%0d want 0000 a00 d0 ww0 acc5",
                  byte_ready0, wr_en0, busy0, done0, wr_addr0, wr_data0, words_written0, acc_n);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         byte_data = 8'($urandom);
         @(negedge clk);
         n_checks++;
         if (wr_en0 !== 1'b0 || busy0 !== 1'b0 || byte_ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL post-reset quiet: got we%b busy%b rdy%b want 000", wr_en0, busy0, byte_ready0);
         end
      end
      byte_valid = 1'b0;
      run_frame("after_reset", 1, 1'b0, 8'h12, 8'h22, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_three_word;
      run_frame("three_word", 3, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_gaps;
      for (int k = 0; k < 4; k++)
         run_frame("gaps", int'($urandom_range(1, 20)), 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_wrap;
      run_frame("wrap", 10, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_restart;
      run_frame("restart_busy", 4, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_full;
      run_frame("full256", 256, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum;
      run_frame("csum_good", 5, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      run_frame("csum_bad", 5, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
      run_frame("csum_clear", 2, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask
`endif

   initial begin
      test_reset;
      test_idle_bytes;
      test_reset_mid;
      test_three_word;
      test_gaps;
      test_wrap;
      test_restart;
      test_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
